// File: rtl/hir_arith_pkg.sv
// Shared definitions for the pipelined arithmetic unit: operation encoding and default sizing.
package hir_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } op_e;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_LATENCY = 2;

  // Tag bits travelling alongside the operands: {op, acc_clr}
  localparam int TAG_W = 3;

  // Register stages between the operand capture and the final ALU stage
  function automatic int mid_depth(input int latency);
    return (latency > 2) ? latency - 2 : 0;
  endfunction

endpackage

// File: rtl/hir_pipe_delay.sv
// Valid-plus-payload delay line; reset clears the valid bits only, payload flops
// load only when their incoming valid is set.
module hir_pipe_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign valid_o = valid_i;
      assign data_o  = data_i;
    end else begin : g_line
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic         valid_q;
        logic [W-1:0] data_q;
        logic         valid_d;
        logic [W-1:0] data_d;

        if (gi == 0) begin : g_head
          assign valid_d = valid_i;
          assign data_d  = data_i;
        end else begin : g_tail
          assign valid_d = g_stage[gi-1].valid_q;
          assign data_d  = g_stage[gi-1].data_q;
        end

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            valid_q <= 1'b0;
          end else begin
            valid_q <= valid_d;
          end
        end

        always_ff @(posedge clk) begin
          if (valid_d) begin
            data_q <= data_d;
          end
        end
      end

      assign valid_o = g_stage[DEPTH-1].valid_q;
      assign data_o  = g_stage[DEPTH-1].data_q;
    end
  endgenerate

endmodule

// File: rtl/hir_arith_unit.sv
// Fixed-latency ADD/SUB/MUL/MAC unit: operand capture, multiplier stages, then a
// final ALU/accumulator stage that owns out, acc and tdone.
module hir_arith_unit
  import hir_arith_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tstart,
  input  logic [1:0]       op,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             tdone,
  output logic [WIDTH-1:0] acc
);

  localparam int OPND_W = TAG_W + 2 * WIDTH;
  localparam int FIN_W  = TAG_W + 3 * WIDTH;

  // Inputs to the final stage
  logic             fin_valid;
  logic [1:0]       fin_op;
  logic             fin_clr;
  logic [WIDTH-1:0] fin_a;
  logic [WIDTH-1:0] fin_b;
  logic [WIDTH-1:0] fin_p;

  generate
    if (LATENCY == 1) begin : g_single
      assign fin_valid = tstart;
      assign fin_op    = op;
      assign fin_clr   = acc_clr;
      assign fin_a     = in1;
      assign fin_b     = in2;
      assign fin_p     = in1 * in2;
    end else begin : g_multi
      logic              s1_valid;
      logic [OPND_W-1:0] s1_data;
      logic [WIDTH-1:0]  s1_a;
      logic [WIDTH-1:0]  s1_b;
      logic [WIDTH-1:0]  s1_p;
      logic [FIN_W-1:0]  fin_data;

      hir_pipe_delay #(
        .DEPTH (1),
        .W     (OPND_W)
      ) u_opnd (
        .clk     (clk),
        .reset   (reset),
        .valid_i (tstart),
        .data_i  ({op, acc_clr, in1, in2}),
        .valid_o (s1_valid),
        .data_o  (s1_data)
      );

      assign s1_a = s1_data[2*WIDTH-1:WIDTH];
      assign s1_b = s1_data[WIDTH-1:0];
      assign s1_p = s1_a * s1_b;

      // Product (and tags/operands) ride the remaining stages so the final add is short
      hir_pipe_delay #(
        .DEPTH (mid_depth(LATENCY)),
        .W     (FIN_W)
      ) u_mid (
        .clk     (clk),
        .reset   (reset),
        .valid_i (s1_valid),
        .data_i  ({s1_data[OPND_W-1:2*WIDTH], s1_a, s1_b, s1_p}),
        .valid_o (fin_valid),
        .data_o  (fin_data)
      );

      assign fin_op  = fin_data[FIN_W-1:FIN_W-2];
      assign fin_clr = fin_data[FIN_W-3];
      assign fin_a   = fin_data[3*WIDTH-1:2*WIDTH];
      assign fin_b   = fin_data[2*WIDTH-1:WIDTH];
      assign fin_p   = fin_data[WIDTH-1:0];
    end
  endgenerate

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             tdone_q;

  // Accumulator only moves here, so back-to-back MACs chain in completion order
  always_comb begin
    out_d = out_q;
    acc_d = acc_q;
    if (fin_valid) begin
      case (op_e'(fin_op))
        OP_ADD: out_d = fin_a + fin_b;
        OP_SUB: out_d = fin_a - fin_b;
        OP_MUL: out_d = fin_p;
        OP_MAC: begin
          acc_d = fin_clr ? fin_p : acc_q + fin_p;
          out_d = acc_d;
        end
        default: out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      acc_q   <= '0;
      tdone_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      acc_q   <= acc_d;
      tdone_q <= fin_valid;
    end
  end

  assign out   = out_q;
  assign acc   = acc_q;
  assign tdone = tdone_q;

endmodule

// File: tb/tb_hir_arith_unit.sv
// Four parameterisations share one stimulus stream; a per-instance issue-order
// scoreboard predicts every completion cycle, result and accumulator value.
module tb_hir_arith_unit;

  localparam int              LAT  [4] = '{2, 3, 1, 4};
  localparam longint unsigned MASK [4] = '{64'hFFFF_FFFF, 64'hFF, 64'hFFFF, 64'hFFFF};
  localparam int              QN       = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        tstart;
  logic [1:0]  op;
  logic        acc_clr;
  logic [31:0] in1;
  logic [31:0] in2;

  logic [31:0] out0, acc0;
  logic [7:0]  out1, acc1;
  logic [15:0] out2, acc2, out3, acc3;
  logic        done0, done1, done2, done3;

  logic [63:0] obs_out [4];
  logic [63:0] obs_acc [4];
  logic        obs_done[4];

  always #5 clk = ~clk;

  hir_arith_unit #(.WIDTH(32), .LATENCY(2)) u_w32_l2 (
    .clk(clk), .reset(reset), .tstart(tstart), .op(op), .acc_clr(acc_clr),
    .in1(in1), .in2(in2), .out(out0), .tdone(done0), .acc(acc0));
  hir_arith_unit #(.WIDTH(8), .LATENCY(3)) u_w8_l3 (
    .clk(clk), .reset(reset), .tstart(tstart), .op(op), .acc_clr(acc_clr),
    .in1(in1[7:0]), .in2(in2[7:0]), .out(out1), .tdone(done1), .acc(acc1));
  hir_arith_unit #(.WIDTH(16), .LATENCY(1)) u_w16_l1 (
    .clk(clk), .reset(reset), .tstart(tstart), .op(op), .acc_clr(acc_clr),
    .in1(in1[15:0]), .in2(in2[15:0]), .out(out2), .tdone(done2), .acc(acc2));
  hir_arith_unit #(.WIDTH(16), .LATENCY(4)) u_w16_l4 (
    .clk(clk), .reset(reset), .tstart(tstart), .op(op), .acc_clr(acc_clr),
    .in1(in1[15:0]), .in2(in2[15:0]), .out(out3), .tdone(done3), .acc(acc3));

  assign obs_out[0] = {32'b0, out0};
  assign obs_out[1] = {56'b0, out1};
  assign obs_out[2] = {48'b0, out2};
  assign obs_out[3] = {48'b0, out3};
  assign obs_acc[0] = {32'b0, acc0};
  assign obs_acc[1] = {56'b0, acc1};
  assign obs_acc[2] = {48'b0, acc2};
  assign obs_acc[3] = {48'b0, acc3};
  assign obs_done[0] = done0;
  assign obs_done[1] = done1;
  assign obs_done[2] = done2;
  assign obs_done[3] = done3;

  int              checks = 0;
  int              passes = 0;
  int              cyc    = 0;
  int              exp_due [4][QN];
  longint unsigned exp_res [4][QN];
  longint unsigned exp_acc [4][QN];
  int              head [4];
  int              tail [4];
  longint unsigned macc [4];
  longint unsigned last_out [4];
  longint unsigned last_acc [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      head[k] = 0; tail[k] = 0;
      macc[k] = 0; last_out[k] = 0; last_acc[k] = 0;
    end
  endfunction

  // Result computed from the operation definitions; in-order completion lets the
  // accumulator be advanced at issue time.
  function automatic void model_issue();
    longint unsigned a, b, p, r;
    for (int k = 0; k < 4; k++) begin
      a = longint'(in1) & MASK[k];
      b = longint'(in2) & MASK[k];
      p = (a * b) & MASK[k];
      case (op)
        2'd0: r = (a + b) & MASK[k];
        2'd1: r = (a - b) & MASK[k];
        2'd2: r = p;
        default: begin
          macc[k] = acc_clr ? p : ((macc[k] + p) & MASK[k]);
          r = macc[k];
        end
      endcase
      exp_due[k][tail[k] % QN] = cyc + LAT[k];
      exp_res[k][tail[k] % QN] = r;
      exp_acc[k][tail[k] % QN] = macc[k];
      tail[k]++;
    end
  endfunction

  task automatic tick();
    logic exp_done;
    @(posedge clk);
    if (tstart && !reset) model_issue();
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_done = 1'b0;
      if (head[k] != tail[k] && exp_due[k][head[k] % QN] == cyc) begin
        exp_done    = 1'b1;
        last_out[k] = exp_res[k][head[k] % QN];
        last_acc[k] = exp_acc[k][head[k] % QN];
        head[k]++;
      end
      chk($sformatf("u%0d_tdone", k), {63'b0, obs_done[k]}, {63'b0, exp_done});
      chk($sformatf("u%0d_out", k), obs_out[k], last_out[k]);
      chk($sformatf("u%0d_acc", k), obs_acc[k], last_acc[k]);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    tstart = 1'b1; op = o; in1 = a; in2 = b; acc_clr = c;
    tick();
    tstart = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in1 = $urandom; in2 = $urandom; op = 2'($urandom); acc_clr = 1'($urandom);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; tstart = 1'b0; op = 2'd0; acc_clr = 1'b0; in1 = '0; in2 = '0;
    model_reset();
    tick();
    tick();
    chk("reset_out", obs_out[0], 64'd0);
    reset = 1'b0;

    // ADD then SUB back-to-back, first issue right after reset release
    issue(2'd0, 32'd5, 32'd7, 1'b0);
    issue(2'd1, 32'd3, 32'd5, 1'b0);
    chk("add_5_7", obs_out[0], 64'd12);
    chk("add_tdone", {63'b0, obs_done[0]}, 64'd1);
    idle(1);
    chk("sub_3_5", obs_out[0], 64'hFFFF_FFFE);
    idle(3);

    // 8-bit multiply wrap
    issue(2'd2, 32'h10, 32'h11, 1'b0);
    idle(2);
    chk("mul8_out", obs_out[1], 64'h10);
    chk("mul8_tdone", {63'b0, obs_done[1]}, 64'd1);
    idle(1);
    chk("mul8_hold", obs_out[1], 64'h10);
    chk("mul8_tdone_low", {63'b0, obs_done[1]}, 64'd0);
    idle(2);

    // MAC chain with an interleaved ADD
    issue(2'd3, 32'd2, 32'd3, 1'b1);
    issue(2'd3, 32'd4, 32'd5, 1'b0);
    chk("mac1_out", obs_out[0], 64'd6);
    issue(2'd3, 32'd1, 32'd1, 1'b0);
    chk("mac2_acc", obs_acc[0], 64'd26);
    issue(2'd0, 32'd9, 32'd9, 1'b0);
    chk("mac3_out", obs_out[0], 64'd27);
    idle(1);
    chk("add_keeps_acc", obs_acc[0], 64'd27);
    chk("add_out", obs_out[0], 64'd18);
    idle(3);

    // Idle hold with toggling inputs
    issue(2'd0, 32'h1200, 32'h34, 1'b0);
    idle(3);
    chk("hold_start", obs_out[0], 64'h1234);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("hold_out", obs_out[0], 64'h1234);
      chk("hold_tdone", {63'b0, obs_done[0]}, 64'd0);
    end

    // Random ops with random issue gaps
    for (int i = 0; i < 300; i++) begin
      tstart  = ($urandom_range(0, 9) < 6);
      op      = 2'($urandom);
      acc_clr = ($urandom_range(0, 3) == 0);
      in1     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      in2     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      tick();
    end
    tstart = 1'b0;
    idle(5);

    // Asynchronous reset while operations are in flight
    issue(2'd2, 32'd7, 32'd9, 1'b0);
    issue(2'd3, 32'd3, 32'd3, 1'b1);
    issue(2'd0, 32'd100, 32'd1, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_u%0d_out", k), obs_out[k], 64'd0);
      chk($sformatf("rst_u%0d_acc", k), obs_acc[k], 64'd0);
      chk($sformatf("rst_u%0d_tdone", k), {63'b0, obs_done[k]}, 64'd0);
    end
    tstart = 1'b1; op = 2'd0; in1 = 32'd50; in2 = 32'd50;
    tick();
    tick();
    tstart = 1'b0;
    reset  = 1'b0;
    issue(2'd0, 32'd1, 32'd1, 1'b0);
    idle(1);
    chk("post_rst_add", obs_out[0], 64'd2);
    idle(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
